bcd_to_b16: RTL and testbench
=============================

Name: bcd_to_b16

Overview:
- Sequential inverse of the 16-bit binary-to-BCD display converter.
- Takes five BCD digits (D5 most significant … D1 least significant) and produces the 16-bit unsigned binary value.
- Iterative multiply-by-10-and-add, one digit per clock, MSD first, with start/busy/valid handshake.
- Used on the input/keypad side to turn entered decimal digits back into the 16-bit operand the display path consumes.
- Flags invalid digits and values above 65535.

Parameters:
- NDIG, 5, number of BCD digits; fixed at 5 in this revision. Bench instantiates the default only.

Ports:
- clk  input  1  single system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- enable  input  1  global advance enable; 0 stalls the block (state and outputs held)
- start  input  1  request conversion; sampled only in IDLE with enable=1
- D5  input  4  BCD digit, ten-thousands
- D4  input  4  BCD digit, thousands
- D3  input  4  BCD digit, hundreds
- D2  input  4  BCD digit, tens
- D1  input  4  BCD digit, units
- busy  output  1  high while a conversion is in progress
- valid  output  1  one-cycle pulse: result outputs updated
- binary  output  16  converted value; 0 when either error flag is set
- err_digit  output  1  some latched digit > 9
- err_ovf  output  1  decimal value > 65535

Behaviour:
- Reset (synchronous, reset=1 at a rising edge): state=IDLE, busy=0, valid=0, binary=0, err_digit=0, err_ovf=0, accumulator=0, digit counter=0. Reset overrides enable and start, and aborts any conversion in progress; no valid pulse for an aborted conversion.
- enable=0: no state, counter, accumulator or output register changes. Exception: a valid pulse already high drops to 0 on the next edge regardless of enable, so it stays exactly one cycle wide.
- States: IDLE, CONV, DONE.
- IDLE, on an edge with enable=1 and start=1:
  - latch D5..D1 into an internal register;
  - acc (17-bit) = 0, cnt = 0;
  - latched digit-error flag = OR over digits of (digit > 9);
  - busy = 1; go to CONV.
  - Otherwise stay in IDLE; start with enable=0 is ignored (not queued).
- CONV, each edge with enable=1:
  - acc = acc*10 + digit[cnt], with cnt 0..4 selecting D5, D4, D3, D2, D1; cnt increments.
  - After the cnt=4 update, go to DONE.
  - Arithmetic is 17-bit; the maximum 99999 fits, and digits > 9 use their raw 4-bit value. The 17-bit bound holds only while no digit exceeds 9; when a digit does, err_digit is set regardless and the accumulator value is don't-care.
- DONE, on the next edge with enable=1:
  - err_digit = latched digit-error flag;
  - err_ovf = (acc > 65535) and not err_digit;
  - binary = 0 if either error flag is set, else acc[15:0];
  - valid = 1, busy = 0; go to IDLE.
- Latency with enable held at 1: start sampled at edge E0; busy high after E0; 5 iterations at E1..E5; outputs and valid update at E6. valid is high for exactly the cycle after E6, and busy falls at the same edge (E6). Each enable=0 cycle adds one cycle of latency.
- start during CONV or DONE: ignored. Digit inputs may change freely after E0.
- Back-to-back: start may be asserted in the cycle valid is high (block is in IDLE); accepted, with the new valid 6 edges later.
- binary and the error flags hold their values until the next DONE or reset.

Test Plan:
- Reset, then start with digits 0 0 0 0 0 -> valid at E6, binary=0, errors 0; busy high from E1 through E5, low after E6.
- Digits 6 5 5 3 5 -> binary=65535, err_ovf=0. Then digits 1 2 3 4 5 back-to-back, start asserted in the valid cycle -> binary=12345.
- Digits 6 5 5 3 6 -> err_ovf=1, binary=0. Digits 9 9 9 9 9 -> err_ovf=1, binary=0.
- Digits 0 0 10 0 0 (D3=4'hA) -> err_digit=1, err_ovf=0, binary=0. Next valid conversion 0 0 0 4 2 -> flags clear, binary=42.
- Start with 3 1 4 1 5; pulse start again at E2; hold enable=0 for 3 cycles during CONV -> exactly one valid, at E9, binary=31415.
- Start with 2 7 1 8 2; assert reset at E3 -> busy=0 and binary=0 at E3, no valid pulse. A fresh start after reset converts normally.

Source files
------------

// File: rtl/bcd_to_b16.sv
// Five-digit BCD to 16-bit binary converter, one digit per clock (MSD first).
// Runs acc = acc*10 + digit with start/busy/valid handshake and digit/overflow flags.
module bcd_to_b16 #(
  parameter int NDIG = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        start,
  input  logic [3:0]  D5,
  input  logic [3:0]  D4,
  input  logic [3:0]  D3,
  input  logic [3:0]  D2,
  input  logic [3:0]  D1,
  output logic        busy,
  output logic        valid,
  output logic [15:0] binary,
  output logic        err_digit,
  output logic        err_ovf
);

  localparam int CW = $clog2(NDIG);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t                state, state_nxt;
  logic [NDIG-1:0][3:0]  dig_in, dig_q;
  logic [NDIG-1:0]       dig_bad;
  logic [16:0]           acc, acc_step;
  logic [CW-1:0]         cnt;
  logic                  derr;

  // Index NDIG-1 is the most significant digit; it is consumed first.
  assign dig_in = {D5, D4, D3, D2, D1};

  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    assign dig_bad[i] = (dig_in[i] > 4'd9);
  end

  // Digits > 9 feed in raw; the result is discarded when err_digit is set.
  assign acc_step = (acc << 3) + (acc << 1) + 17'(dig_q[NDIG-1]);

  always_ff @(posedge clk) begin
    if (reset)       state <= IDLE;
    else if (enable) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CONV;
      CONV:    if (cnt == CW'(NDIG-1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dig_q     <= '0;
      acc       <= '0;
      cnt       <= '0;
      derr      <= 1'b0;
      valid     <= 1'b0;
      binary    <= '0;
      err_digit <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      // valid is a single-cycle pulse even if enable drops right after DONE.
      valid <= 1'b0;
      if (enable) begin
        case (state)
          IDLE: if (start) begin
            dig_q <= dig_in;
            acc   <= '0;
            cnt   <= '0;
            derr  <= |dig_bad;
          end
          CONV: begin
            acc   <= acc_step;
            cnt   <= cnt + 1'b1;
            dig_q <= {dig_q[NDIG-2:0], 4'h0};
          end
          DONE: begin
            err_digit <= derr;
            err_ovf   <= acc[16] & ~derr;
            binary    <= (derr | acc[16]) ? 16'd0 : acc[15:0];
            valid     <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bcd_to_b16.sv
// Directed bench for bcd_to_b16: latency, results, flags, stall, restart and reset abort.
module tb_bcd_to_b16;

  logic        clk = 1'b0;
  logic        reset, enable, start;
  logic [3:0]  D5, D4, D3, D2, D1;
  logic        busy, valid, err_digit, err_ovf;
  logic [15:0] binary;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  bcd_to_b16 dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start),
    .D5(D5), .D4(D4), .D3(D3), .D2(D2), .D1(D1),
    .busy(busy), .valid(valid), .binary(binary),
    .err_digit(err_digit), .err_ovf(err_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic start_conv(input logic [3:0] a, b, c, d, e);
    {D5, D4, D3, D2, D1} = {a, b, c, d, e};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for valid, checks edge count and results; stays in the valid cycle.
  task automatic wait_valid(input string tag, input int lat, input logic [15:0] bin,
                            input logic ed, input logic eo);
    int n = 0;
    while (!valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, n, lat);
    chk({tag, " binary"}, binary, bin);
    chk({tag, " err_digit"}, err_digit, ed);
    chk({tag, " err_ovf"}, err_ovf, eo);
    chk({tag, " busy"}, busy, 1'b0);
  endtask

  task automatic after_valid(input string tag);
    @(negedge clk);
    chk({tag, " valid drop"}, valid, 1'b0);
  endtask

  initial begin
    int nv;
    reset = 1'b1; enable = 1'b1; start = 1'b0;
    {D5, D4, D3, D2, D1} = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst busy", busy, 0);
    chk("rst valid", valid, 0);
    chk("rst binary", binary, 0);
    chk("rst err_digit", err_digit, 0);
    chk("rst err_ovf", err_ovf, 0);

    // Exact latency: busy through E5, valid and busy low after E6.
    start_conv(0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      chk("zero busy", busy, 1);
      chk("zero no valid", valid, 0);
      @(negedge clk);
    end
    chk("zero valid", valid, 1);
    chk("zero busy low", busy, 0);
    chk("zero binary", binary, 0);
    chk("zero errs", {err_digit, err_ovf}, 0);
    after_valid("zero");

    // Max value, then back-to-back start in the valid cycle.
    start_conv(6, 5, 5, 3, 5);
    wait_valid("65535", 6, 16'd65535, 0, 0);
    start_conv(1, 2, 3, 4, 5);
    chk("b2b busy", busy, 1);
    wait_valid("12345", 6, 16'd12345, 0, 0);
    after_valid("12345");

    start_conv(6, 5, 5, 3, 6);
    wait_valid("65536", 6, 16'd0, 0, 1);
    after_valid("65536");
    start_conv(9, 9, 9, 9, 9);
    wait_valid("99999", 6, 16'd0, 0, 1);
    after_valid("99999");

    start_conv(0, 0, 4'hA, 0, 0);
    wait_valid("digerr", 6, 16'd0, 1, 0);
    after_valid("digerr");
    start_conv(0, 0, 0, 4, 2);
    wait_valid("42", 6, 16'd42, 0, 0);
    after_valid("42");

    // Start with enable low is not queued.
    enable = 1'b0; start = 1'b1;
    @(negedge clk);
    enable = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    chk("en0 start ignored", busy, 0);

    // Repeated start at E2 ignored; 3 stalled edges delay valid to E9.
    start_conv(3, 1, 4, 1, 5);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall busy", busy, 1);
      chk("stall no valid", valid, 0);
    end
    enable = 1'b1;
    wait_valid("31415", 4, 16'd31415, 0, 0);
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (valid) nv++;
    end
    chk("31415 single valid", nv, 0);
    chk("31415 hold binary", binary, 16'd31415);

    // Reset at E3 aborts without a valid pulse.
    start_conv(2, 7, 1, 8, 2);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort binary", binary, 0);
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (valid) nv++;
    end
    chk("abort no valid", nv, 0);
    start_conv(2, 7, 1, 8, 2);
    wait_valid("27182", 6, 16'd27182, 0, 0);
    after_valid("27182");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
